// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding, field widths and
// well-known bus constants used by the target and bus-monitor logic.
package i2c_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;
    localparam int unsigned ADDR_W    = 7;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT     = '1;
    localparam logic                 I2C_RW_READ  = 1'b1;
    localparam logic [ADDR_W-1:0]    ADT7420_ADDR = 7'h48;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        MACK
    } i2c_state_e;

endpackage

// File: rtl/i2c_bus_cond.sv
// I2C bus condition decoder: synchronizes raw SCL/SDA and reports SCL edges,
// START and STOP as registered one-clk pulses, plus the synchronized SDA level.
// Ports:
//   clk, rst_n      system clock, async active-low reset
//   scl_i, sda_i    raw pad inputs (asynchronous)
//   scl_rise_o      SCL rising edge pulse
//   scl_fall_o      SCL falling edge pulse
//   start_o         SDA fell while SCL high
//   stop_o          SDA rose while SCL high
//   sda_o           synchronized SDA level, aligned with the pulses
module i2c_bus_cond (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o,
    output logic sda_o
);

    // [0],[1]: 2-FF synchronizer, [2]: history stage
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    logic rise_d, fall_d, start_d, stop_d;
    logic rise_q, fall_q, start_q, stop_q, sda_lvl_q;

    // Decode from synchronized samples; registered so pads-to-pulse is 3 clk
    always_comb begin
        rise_d  = scl_q[1] & ~scl_q[2];
        fall_d  = ~scl_q[1] & scl_q[2];
        start_d = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
        stop_d  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
    end

    // Synchronizers preset to an idle (high) bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q     <= '1;
            sda_q     <= '1;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            sda_lvl_q <= 1'b1;
        end else begin
            scl_q     <= {scl_q[1:0], scl_i};
            sda_q     <= {sda_q[1:0], sda_i};
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
            sda_lvl_q <= sda_q[1];
        end
    end

    assign scl_rise_o = rise_q;
    assign scl_fall_o = fall_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;
    assign sda_o      = sda_lvl_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target emulating a register-mapped sensor (ADT7420-style): decodes
// address, register pointer and data bytes, drives SDA open-drain, and exposes
// a byte-wide register port with an auto-incrementing pointer.
// Ports:
//   clk, rst_n         system clock (>= 20x SCL), async active-low reset
//   scl_in, sda_in     raw pad inputs
//   sda_oe             1 = pull SDA low
//   reg_ptr            current register pointer
//   rd_data            register contents at reg_ptr (sampled on byte load)
//   wr_strobe/wr_data  one-clk write of wr_data to register reg_ptr
//   busy               addressed transaction in progress
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] TARGET_ADDR = ADT7420_ADDR,
    parameter logic [BYTE_W-1:0] PTR_RESET   = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic [BYTE_W-1:0] reg_ptr,
    input  logic [BYTE_W-1:0] rd_data,
    output logic              wr_strobe,
    output logic [BYTE_W-1:0] wr_data,
    output logic              busy
);

    logic scl_rise, scl_fall, bus_start, bus_stop, sda_lvl;

    i2c_bus_cond u_bus_cond (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_i      (scl_in),
        .sda_i      (sda_in),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (bus_start),
        .stop_o     (bus_stop),
        .sda_o      (sda_lvl)
    );

    i2c_state_e           state_q, state_d;
    logic [BYTE_W-1:0]    shreg_q, shreg_d;
    logic [BIT_CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic                 rw_q, rw_d;
    // ACK states: ACK is being driven; MACK: master acknowledged
    logic                 ack_q, ack_d;
    logic [BYTE_W-1:0]    ptr_q, ptr_d;
    logic [BYTE_W-1:0]    wdata_q, wdata_d;
    logic                 strobe_q, strobe_d;
    logic                 oe_q, oe_d;
    logic                 busy_q, busy_d;

    logic [BYTE_W-1:0]    byte_in;
    logic                 last_bit;

    assign byte_in  = {shreg_q[BYTE_W-2:0], sda_lvl};
    assign last_bit = (bitcnt_q == LAST_BIT);

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        rw_d     = rw_q;
        ack_d    = ack_q;
        ptr_d    = ptr_q;
        wdata_d  = wdata_q;
        strobe_d = 1'b0;
        oe_d     = oe_q;
        busy_d   = busy_q;

        case (state_q)
            IDLE: ;
            ADDR, PTR, WDATA: begin
                if (scl_rise) begin
                    shreg_d  = byte_in;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (last_bit) begin
                        ack_d = 1'b0;
                        if (state_q == ADDR) begin
                            if (byte_in[BYTE_W-1:1] == TARGET_ADDR) begin
                                rw_d    = byte_in[0];
                                busy_d  = 1'b1;
                                state_d = ADDR_ACK;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = IDLE;
                            end
                        end else if (state_q == PTR) begin
                            ptr_d   = byte_in;
                            state_d = PTR_ACK;
                        end else begin
                            wdata_d  = byte_in;
                            strobe_d = 1'b1;
                            state_d  = WDATA_ACK;
                        end
                    end
                end
            end
            ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                // First fall drives ACK, second fall releases and moves on
                if (scl_fall) begin
                    if (!ack_q) begin
                        oe_d  = 1'b1;
                        ack_d = 1'b1;
                    end else begin
                        oe_d     = 1'b0;
                        ack_d    = 1'b0;
                        bitcnt_d = '0;
                        if (state_q == ADDR_ACK) begin
                            if (rw_q == I2C_RW_READ) begin
                                shreg_d = rd_data;
                                oe_d    = ~rd_data[BYTE_W-1];
                                state_d = RDATA;
                            end else begin
                                state_d = PTR;
                            end
                        end else if (state_q == PTR_ACK) begin
                            state_d = WDATA;
                        end else begin
                            ptr_d   = ptr_q + 8'd1;
                            state_d = WDATA;
                        end
                    end
                end
            end
            RDATA: begin
                if (scl_fall) begin
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (last_bit) begin
                        oe_d    = 1'b0;
                        ack_d   = 1'b0;
                        state_d = MACK;
                    end else begin
                        shreg_d = {shreg_q[BYTE_W-2:0], 1'b0};
                        oe_d    = ~shreg_q[BYTE_W-2];
                    end
                end
            end
            MACK: begin
                if (scl_rise && !ack_q) begin
                    if (!sda_lvl) begin
                        ptr_d = ptr_q + 8'd1;
                        ack_d = 1'b1;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else if (scl_fall && ack_q) begin
                    // Pointer already advanced, so rd_data is the next register
                    shreg_d  = rd_data;
                    oe_d     = ~rd_data[BYTE_W-1];
                    bitcnt_d = '0;
                    ack_d    = 1'b0;
                    state_d  = RDATA;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bus conditions override everything; STOP wins over START
        if (bus_start) begin
            oe_d     = 1'b0;
            bitcnt_d = '0;
            ack_d    = 1'b0;
            state_d  = ADDR;
        end
        if (bus_stop) begin
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            ack_d   = 1'b0;
            state_d = IDLE;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            rw_q     <= 1'b0;
            ack_q    <= 1'b0;
            ptr_q    <= PTR_RESET;
            wdata_q  <= '0;
            strobe_q <= 1'b0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            rw_q     <= rw_d;
            ack_q    <= ack_d;
            ptr_q    <= ptr_d;
            wdata_q  <= wdata_d;
            strobe_q <= strobe_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
        end
    end

    assign sda_oe    = oe_q;
    assign reg_ptr   = ptr_q;
    assign wr_strobe = strobe_q;
    assign wr_data   = wdata_q;
    assign busy      = busy_q;

endmodule
